// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks a contiguous address range of a RAM read port
// and presents the words as a valid/ready stream with one output register.
//
// Handshake: a beat transfers on a rising edge where out_valid=1 and
// out_ready=1. While out_valid=1 and out_ready=0, out_data, out_valid and
// out_last hold. out_valid is purely registered and never looks at
// out_ready.
module ram_stream_reader #(
  parameter int DATA_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_BITWIDTH-1:0] base_addr,
  input  logic [ADDR_BITWIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_BITWIDTH-1:0] addr_rd,
  input  logic [DATA_BITWIDTH-1:0] data_rd,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [1:0]               dbg_state_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_BITWIDTH:0]   REM_ONE  = 1;
  localparam logic [ADDR_BITWIDTH:0]   REM_ZERO = '0;
  localparam logic [ADDR_BITWIDTH-1:0] ADDR_ONE = 1;

  logic [1:0]               state_q, state_d;
  logic [ADDR_BITWIDTH-1:0] addr_q,  addr_d;
  logic [ADDR_BITWIDTH:0]   rem_q,   rem_d;
  logic [DATA_BITWIDTH-1:0] data_q,  data_d;
  logic                     valid_q, valid_d;
  logic                     last_q,  last_d;
  logic                     load;

  // The output register may take a new word when it is empty or being drained.
  assign load = !valid_q || out_ready;

  // Next-state logic: sequencing of address, word count and output register.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != REM_ZERO) begin
            addr_d  = base_addr;
            rem_d   = length;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (load) begin
          // The RAM word is sampled here, so writes up to this cycle are seen.
          data_d  = data_rd;
          valid_d = 1'b1;
          last_d  = (rem_q == REM_ONE);
          rem_d   = rem_q - REM_ONE;
          addr_d  = addr_q + ADDR_ONE;
          if (rem_q == REM_ONE) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that drops any beat in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign addr_rd     = addr_q;
  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_last    = last_q;
  assign dbg_state_o = state_q;

endmodule
